// File: rtl/change_dispenser.sv
// Greedy coin-return sequencer: pays out changeCents as timed ejector pulses (quarter, dime, nickel).
// Define CHANGE_DISPENSER_DIME_EN to enable the dime ejector; otherwise dimeOut is tied low.
module change_dispenser #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int PULSE_US = 200_000,
    parameter int GAP_US   = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startPulse,
    input  logic [6:0] changeCents,
    output logic       busy,
    output logic       doneTick,
    output logic       quarterOut,
    output logic       dimeOut,
    output logic       nickelOut,
    output logic [6:0] remainingCents,
    output logic       errorFlag
);
    localparam int PULSE_CYCLES = CLK_HZ / 1_000_000 * PULSE_US;
    localparam int GAP_CYCLES   = CLK_HZ / 1_000_000 * GAP_US;
    localparam int MAX_CYCLES   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW           = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_QUARTER, COIN_DIME, COIN_NICKEL} coin_t;

    state_t        state, nextState;
    coin_t         coin, nextCoin;
    logic [CW-1:0] cnt, nextCnt;
    logic [6:0]    nextRemaining;
    logic          nextError;

    assign busy     = (state != IDLE);
    assign doneTick = (state == DONE);

    always_comb begin
        nextState     = state;
        nextCoin      = coin;
        nextCnt       = cnt;
        nextRemaining = remainingCents;
        nextError     = errorFlag;
        case (state)
            IDLE: begin
                if (startPulse) begin
                    nextRemaining = changeCents;
                    nextError     = (changeCents % 7'd5) != 7'd0;
                    nextState     = SELECT;
                end
            end
            SELECT: begin
                nextCnt = '0;
                // A coin is only chosen when it fits, so the subtraction cannot wrap.
                if (remainingCents >= 7'd25) begin
                    nextCoin      = COIN_QUARTER;
                    nextRemaining = remainingCents - 7'd25;
                    nextState     = PULSE;
                end
`ifdef CHANGE_DISPENSER_DIME_EN
                else if (remainingCents >= 7'd10) begin
                    nextCoin      = COIN_DIME;
                    nextRemaining = remainingCents - 7'd10;
                    nextState     = PULSE;
                end
`endif
                else if (remainingCents >= 7'd5) begin
                    nextCoin      = COIN_NICKEL;
                    nextRemaining = remainingCents - 7'd5;
                    nextState     = PULSE;
                end else begin
                    nextCoin  = COIN_NONE;
                    nextState = DONE;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    nextCnt   = '0;
                    nextState = GAP;
                end else begin
                    nextCnt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    nextCnt   = '0;
                    nextState = SELECT;
                end else begin
                    nextCnt = cnt + 1'b1;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Ejectors are registered from the next state so they line up exactly with PULSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            coin           <= COIN_NONE;
            cnt            <= '0;
            remainingCents <= '0;
            errorFlag      <= 1'b0;
            quarterOut     <= 1'b0;
            nickelOut      <= 1'b0;
        end else begin
            state          <= nextState;
            coin           <= nextCoin;
            cnt            <= nextCnt;
            remainingCents <= nextRemaining;
            errorFlag      <= nextError;
            quarterOut     <= (nextState == PULSE) && (nextCoin == COIN_QUARTER);
            nickelOut      <= (nextState == PULSE) && (nextCoin == COIN_NICKEL);
        end
    end

`ifdef CHANGE_DISPENSER_DIME_EN
    always_ff @(posedge clk) begin
        if (reset) dimeOut <= 1'b0;
        else       dimeOut <= (nextState == PULSE) && (nextCoin == COIN_DIME);
    end
`else
    assign dimeOut = 1'b0;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (1 MHz clock, 4-cycle pulse, 2-cycle gap).
module tb_change_dispenser;
    localparam int CLK_HZ = 1_000_000, PULSE_US = 4, GAP_US = 2;
    localparam int Q = 4, D = 2, N = 1;  // ejector code {quarter,dime,nickel}
    localparam int CAP = 36;

    logic       clk = 1'b0;
    logic       reset, startPulse;
    logic [6:0] changeCents;
    logic       busy, doneTick, quarterOut, dimeOut, nickelOut, errorFlag;
    logic [6:0] remainingCents;

    change_dispenser #(.CLK_HZ(CLK_HZ), .PULSE_US(PULSE_US), .GAP_US(GAP_US)) dut (
        .clk(clk), .reset(reset), .startPulse(startPulse), .changeCents(changeCents),
        .busy(busy), .doneTick(doneTick), .quarterOut(quarterOut), .dimeOut(dimeOut),
        .nickelOut(nickelOut), .remainingCents(remainingCents), .errorFlag(errorFlag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [2:0] capE[64];
    logic       capBusy[64], capDone[64], capErr[64];
    logic [6:0] capRem[64];
    logic [2:0] expE[64];
    int         expDone;

    // Index k holds outputs sampled at the k-th falling edge after the start edge.
    task automatic startAndCapture(input logic [6:0] cents);
        @(negedge clk);
        startPulse  = 1'b1;
        changeCents = cents;
        for (int k = 1; k < CAP; k++) begin
            @(negedge clk);
            startPulse = 1'b0;
            capE[k]    = {quarterOut, dimeOut, nickelOut};
            capBusy[k] = busy;
            capDone[k] = doneTick;
            capErr[k]  = errorFlag;
            capRem[k]  = remainingCents;
        end
    endtask

    // Expected trace: each coin = 1 select cycle, 4 pulse cycles, 2 gap cycles.
    task automatic buildExp(input int c0, input int c1, input int c2, input int c3);
        int coins[4];
        int k;
        coins = '{c0, c1, c2, c3};
        for (int i = 0; i < 64; i++) expE[i] = 3'b000;
        k = 1;
        for (int i = 0; i < 4; i++) begin
            if (coins[i] != 0) begin
                for (int j = 0; j < 4; j++) expE[k + 1 + j] = 3'(coins[i]);
                k += 7;
            end
        end
        expDone = k + 1;
    endtask

    task automatic test_reset;
        reset = 1'b1; startPulse = 1'b0; changeCents = 7'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if ({busy, doneTick, quarterOut, dimeOut, nickelOut, errorFlag, remainingCents} !== 13'd0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: outputs=%b required all zero", k,
                         {busy, doneTick, quarterOut, dimeOut, nickelOut, errorFlag, remainingCents});
            end
        end
    endtask

    task automatic test_35;
        int bad, doneAt;
`ifdef CHANGE_DISPENSER_DIME_EN
        buildExp(Q, D, 0, 0);
`else
        buildExp(Q, N, N, 0);
`endif
        startAndCapture(7'd35);
        bad = -1; doneAt = -1;
        for (int k = 1; k < CAP; k++) begin
            if (capE[k] !== expE[k] && bad < 0) bad = k;
            if (capDone[k] === 1'b1 && doneAt < 0) doneAt = k;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL c35_ejectors cycle %0d: got %b required %b", bad, capE[bad], expE[bad]);
        end
        tests++;
        if (doneAt != expDone) begin
            fails++;
            $display("FAIL c35_done_time: got %0d required %0d", doneAt, expDone);
        end
        tests++;
        if ({capRem[1], capRem[2], capRem[8], capRem[CAP-1]} !== {7'd35, 7'd10, 7'd10, 7'd0}) begin
            fails++;
            $display("FAIL c35_remaining: got %0d %0d %0d %0d required 35 10 10 0",
                     capRem[1], capRem[2], capRem[8], capRem[CAP-1]);
        end
        tests++;
        if ({capBusy[1], capBusy[expDone], capBusy[expDone+1], capDone[expDone+1], capErr[1]} !== 5'b11000) begin
            fails++;
            $display("FAIL c35_busy_done: got %b required 11000",
                     {capBusy[1], capBusy[expDone], capBusy[expDone+1], capDone[expDone+1], capErr[1]});
        end
    endtask

    task automatic test_zero;
        int bad;
        buildExp(0, 0, 0, 0);
        startAndCapture(7'd0);
        bad = -1;
        for (int k = 1; k < CAP; k++) if (capE[k] !== 3'b000 && bad < 0) bad = k;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL zero_no_eject cycle %0d: got %b required 000", bad, capE[bad]);
        end
        tests++;
        if ({capBusy[1], capBusy[2], capBusy[3], capDone[1], capDone[2], capDone[3]} !== 6'b110010) begin
            fails++;
            $display("FAIL zero_timing: busy/done got %b required 110010",
                     {capBusy[1], capBusy[2], capBusy[3], capDone[1], capDone[2], capDone[3]});
        end
    endtask

    task automatic test_42;
        int bad, doneAt;
`ifdef CHANGE_DISPENSER_DIME_EN
        buildExp(Q, D, N, 0);
`else
        buildExp(Q, N, N, N);
`endif
        startAndCapture(7'd42);
        bad = -1; doneAt = -1;
        for (int k = 1; k < CAP; k++) begin
            if (capE[k] !== expE[k] && bad < 0) bad = k;
            if (capDone[k] === 1'b1 && doneAt < 0) doneAt = k;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL c42_ejectors cycle %0d: got %b required %b", bad, capE[bad], expE[bad]);
        end
        tests++;
        if (doneAt != expDone) begin
            fails++;
            $display("FAIL c42_done_time: got %0d required %0d", doneAt, expDone);
        end
        tests++;
        if ({capRem[CAP-1], capErr[1], capErr[CAP-1]} !== {7'd2, 2'b11}) begin
            fails++;
            $display("FAIL c42_residue_error: rem=%0d err=%b%b required rem=2 err=11",
                     capRem[CAP-1], capErr[1], capErr[CAP-1]);
        end
    endtask

    task automatic test_20;
        int bad, doneAt;
`ifdef CHANGE_DISPENSER_DIME_EN
        buildExp(D, D, 0, 0);
`else
        buildExp(N, N, N, N);
`endif
        startAndCapture(7'd20);
        bad = -1; doneAt = -1;
        for (int k = 1; k < CAP; k++) begin
            if (capE[k] !== expE[k] && bad < 0) bad = k;
            if (capDone[k] === 1'b1 && doneAt < 0) doneAt = k;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL c20_ejectors cycle %0d: got %b required %b", bad, capE[bad], expE[bad]);
        end
        tests++;
        if (doneAt != expDone) begin
            fails++;
            $display("FAIL c20_done_time: got %0d required %0d", doneAt, expDone);
        end
        tests++;
        if ({capErr[1], capRem[1], capRem[CAP-1]} !== {1'b0, 7'd20, 7'd0}) begin
            fails++;
            $display("FAIL c20_error_cleared: err=%b rem=%0d/%0d required err=0 rem=20/0",
                     capErr[1], capRem[1], capRem[CAP-1]);
        end
    endtask

    task automatic test_busy_ignore_and_reset;
        logic [2:0] secondCoin;
`ifdef CHANGE_DISPENSER_DIME_EN
        secondCoin = 3'(D);
`else
        secondCoin = 3'(N);
`endif
        @(negedge clk);
        startPulse = 1'b1; changeCents = 7'd35;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            startPulse = (k == 3);
            if (k == 3) changeCents = 7'd15;
            if (k == 5) begin
                tests++;
                if ({quarterOut, dimeOut, nickelOut, remainingCents} !== {3'(Q), 7'd10}) begin
                    fails++;
                    $display("FAIL ignore_start: ejectors=%b rem=%0d required 100 rem=10",
                             {quarterOut, dimeOut, nickelOut}, remainingCents);
                end
            end
            if (k == 10) begin
                tests++;
                if ({quarterOut, dimeOut, nickelOut} !== secondCoin) begin
                    fails++;
                    $display("FAIL second_pulse: got %b required %b",
                             {quarterOut, dimeOut, nickelOut}, secondCoin);
                end
                reset = 1'b1;
            end
        end
        @(negedge clk);
        tests++;
        if ({busy, doneTick, quarterOut, dimeOut, nickelOut, errorFlag, remainingCents} !== 13'd0) begin
            fails++;
            $display("FAIL reset_mid_payout: outputs=%b required all zero",
                     {busy, doneTick, quarterOut, dimeOut, nickelOut, errorFlag, remainingCents});
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if ({busy, doneTick, quarterOut, dimeOut, nickelOut, remainingCents} !== 12'd0) begin
            fails++;
            $display("FAIL idle_after_reset: outputs=%b required all zero",
                     {busy, doneTick, quarterOut, dimeOut, nickelOut, remainingCents});
        end
    endtask

    initial begin
        reset = 1'b1; startPulse = 1'b0; changeCents = 7'd0;
        test_reset;
        test_35;
        test_zero;
        test_42;
        test_20;
        test_busy_ignore_and_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
